// File: rtl/gp2y10_sampler.sv
// GP2Y10 optical dust sensor controller: periodic IR-LED pulse, one ADC
// capture per period, block averaging of 2^AVG_LOG2 samples and a
// hysteretic dust alarm against a runtime threshold.
module gp2y10_sampler #(
    parameter int DATA_W         = 8,
    parameter int PERIOD_CYC     = 500000,
    parameter int PULSE_CYC      = 16000,
    parameter int SAMPLE_CYC     = 15000,
    parameter int AVG_LOG2       = 3,
    parameter int HYST           = 4,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_adc_data,
    input  logic [DATA_W-1:0] i_thresh,
    output logic              o_led,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_sample_vld,
    output logic [DATA_W-1:0] o_avg,
    output logic              o_avg_vld,
    output logic              o_alarm,
    output logic              o_busy
);

    localparam int CNT_W  = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int SCNT_W = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_PULSE  = CNT_W'(PULSE_CYC);
    localparam logic [CNT_W-1:0]  CNT_SAMPLE = CNT_W'(SAMPLE_CYC);
    localparam logic [SCNT_W-1:0] SCNT_LAST  = SCNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [DATA_W:0]   HYST_X     = (DATA_W + 1)'(HYST);
    localparam logic              LED_OFF    = LED_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic              LED_ON     = ~LED_OFF;

    // Reject parameter sets where the capture point is outside the pulse
    // or the pulse does not fit inside the period.
    generate
        if (!(SAMPLE_CYC >= 0 && SAMPLE_CYC < PULSE_CYC && PULSE_CYC < PERIOD_CYC &&
              AVG_LOG2 >= 0 && AVG_LOG2 <= 8)) begin : g_param_check
            $error("gp2y10_sampler: illegal parameter set");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic [DATA_W-1:0]  sample_q, sample_d;
    logic               sample_vld_q, sample_vld_d;
    logic [DATA_W-1:0]  avg_q, avg_d;
    logic               avg_vld_q, avg_vld_d;
    logic               alarm_q, alarm_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;

    logic [ACC_W-1:0]   sum_s;
    logic [DATA_W-1:0]  avg_s;

    // Alarm decision for a freshly completed average: set at or above the
    // threshold, release only once the average is more than HYST below it.
    function automatic logic alarm_next(input logic [DATA_W-1:0] avg,
                                        input logic [DATA_W-1:0] thr,
                                        input logic              cur);
        logic [DATA_W:0] avg_plus;
        avg_plus = {1'b0, avg} + HYST_X;
        if (avg >= thr) begin
            return 1'b1;
        end else if (avg_plus < {1'b0, thr}) begin
            return 1'b0;
        end else begin
            return cur;
        end
    endfunction

    // The accumulator is sized for 2^AVG_LOG2 full-scale samples, so the sum cannot wrap.
    assign sum_s = acc_q + ACC_W'(i_adc_data);
    assign avg_s = DATA_W'(sum_s >> AVG_LOG2);

    // Next-state logic: period counter, capture/accumulate, averaging, alarm and LED.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        scnt_d       = scnt_q;
        sample_d     = sample_q;
        sample_vld_d = 1'b0;
        avg_d        = avg_q;
        avg_vld_d    = 1'b0;
        alarm_d      = alarm_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_SAMPLE) begin
                    sample_d     = i_adc_data;
                    sample_vld_d = 1'b1;
                    if (scnt_q == SCNT_LAST) begin
                        avg_d     = avg_s;
                        avg_vld_d = 1'b1;
                        acc_d     = '0;
                        scnt_d    = '0;
                        alarm_d   = alarm_next(avg_s, i_thresh, alarm_q);
                    end else begin
                        acc_d  = sum_s;
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end else begin
                    sample_vld_d = 1'b0;
                end

                // i_en only matters at the period boundary; a partial block is dropped on stop.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (i_en) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        scnt_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // LED and busy are registered from the next state so they line up with cnt.
        if (state_d == ST_RUN && cnt_d < CNT_PULSE) begin
            led_d = LED_ON;
        end else begin
            led_d = LED_OFF;
        end
        busy_d = (state_d == ST_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            scnt_q       <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            avg_q        <= '0;
            avg_vld_q    <= 1'b0;
            alarm_q      <= 1'b0;
            led_q        <= LED_OFF;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            scnt_q       <= scnt_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            avg_q        <= avg_d;
            avg_vld_q    <= avg_vld_d;
            alarm_q      <= alarm_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
        end
    end

    assign o_led        = led_q;
    assign o_sample     = sample_q;
    assign o_sample_vld = sample_vld_q;
    assign o_avg        = avg_q;
    assign o_avg_vld    = avg_vld_q;
    assign o_alarm      = alarm_q;
    assign o_busy       = busy_q;

endmodule
